// File: rtl/nn_pkg.sv
// Shared neuron-datapath definitions: accumulator width derivation, counter width
// and the reset value used by the valid/data stage registers.
package nn_pkg;

    localparam int   SAT_CNT_W       = 16;
    localparam logic STAGE_VALID_RST = 1'b0;

    function automatic int acc_width_f(input int width, input int accumulations);
        return width + $clog2(accumulations);
    endfunction

    // Round-half-up bias added before the right shift; zero when not rounding.
    function automatic int rnd_value_f(input int shift, input bit round_en);
        if (!round_en || shift == 0) begin
            return 0;
        end
        return 1 << (shift - 1);
    endfunction

endpackage

// File: rtl/act_stage_reg.sv
// One pipeline slot: a valid bit plus a data word, both advancing only when en_i is high.
module act_stage_reg
    import nn_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Data only loads alongside a valid token so bubbles leave the last result in place.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= STAGE_VALID_RST;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/act_requant.sv
// Bias add, ReLU + shift rescale and saturation to a WIDTH-bit activation, three stages.
// Build option ACT_ROUND_EN: round-half-up before the shift (truncate when undefined).
module act_requant
    import nn_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ACCUMULATIONS = 3,
    parameter int SHIFT         = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [acc_width_f(WIDTH, ACCUMULATIONS)-1:0] acc_data,
    input  logic [acc_width_f(WIDTH, ACCUMULATIONS):0]   bias,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [WIDTH-1:0]                             act_data,
    output logic                                         act_sat,
    output logic [SAT_CNT_W-1:0]                         sat_count
);

    localparam int ACC_WIDTH = acc_width_f(WIDTH, ACCUMULATIONS);
    localparam int SUM_W     = ACC_WIDTH + 2;
`ifdef ACT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif
    localparam logic [SUM_W-1:0] RND_V   = SUM_W'(rnd_value_f(SHIFT, ROUND_EN));
    localparam logic [SUM_W-1:0] ACT_MAX = SUM_W'((1 << WIDTH) - 1);

    logic             en;
    logic             v1, v2, v3;
    logic [SUM_W-1:0] sum_d, sum_q;
    logic [SUM_W-1:0] r_rnd, r_d, r_q;
    logic [WIDTH:0]   s3_d, s3_q;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    assign en       = !v3 || out_ready;
    assign in_ready = en;

    // Two guard bits make the signed sum overflow-free; zero-extend acc, sign-extend bias.
    assign sum_d = {2'b00, acc_data} + {bias[ACC_WIDTH], bias};

    always_comb begin
        r_rnd = sum_q + RND_V;
        r_d   = '0;
        if (!sum_q[SUM_W-1]) begin
            r_d = r_rnd >> SHIFT;
        end
    end

    always_comb begin
        s3_d = {1'b0, r_q[WIDTH-1:0]};
        if (r_q > ACT_MAX) begin
            s3_d = {1'b1, {WIDTH{1'b1}}};
        end
    end

    act_stage_reg #(.DW(SUM_W)) u_s1 (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .valid_i (in_valid),
        .data_i  (sum_d),
        .valid_o (v1),
        .data_o  (sum_q)
    );

    act_stage_reg #(.DW(SUM_W)) u_s2 (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .valid_i (v1),
        .data_i  (r_d),
        .valid_o (v2),
        .data_o  (r_q)
    );

    act_stage_reg #(.DW(WIDTH + 1)) u_s3 (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .valid_i (v2),
        .data_i  (s3_d),
        .valid_o (v3),
        .data_o  (s3_q)
    );

    assign out_valid = v3;
    assign act_sat   = s3_q[WIDTH];
    assign act_data  = s3_q[WIDTH-1:0];

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (v3 && out_ready && s3_q[WIDTH] && (sat_cnt_q != {SAT_CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_act_requant.sv
// Self-checking bench for act_requant: directed cases plus random traffic scored
// against an arithmetic reference with an expected-result queue.
module tb_act_requant;

    localparam int WIDTH = 8;
    localparam int ACC_W = 10;
    localparam int SHIFT = 2;
`ifdef ACT_ROUND_EN
    localparam int RND = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
    localparam int EXP_102 = 26;
`else
    localparam int RND = 0;
    localparam int EXP_102 = 25;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_data;
    logic [ACC_W:0]   bias;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] act_data;
    logic             act_sat;
    logic [15:0]      sat_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int model_cnt = 0;
    int exp_q[$];

    act_requant #(.WIDTH(WIDTH), .ACCUMULATIONS(3), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_data  (acc_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_data  (act_data),
        .act_sat   (act_sat),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns {sat, act} as sat*256 + act.
    function automatic int ref_res(input int a, input int b);
        int s;
        int r;
        s = a + b;
        if (s < 0) r = 0;
        else       r = (s + RND) / (1 << SHIFT);
        if (r > 255) return 256 + 255;
        return r;
    endfunction

    // Inputs change at posedge+2, so at negedge all handshake signals are settled.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("mon_act", act_data, e % 256);
                    chk("mon_sat", act_sat, e / 256);
                    chk("mon_satcnt", sat_count, model_cnt);
                    if (e / 256 == 1 && model_cnt < 65535) model_cnt++;
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_res(int'(acc_data), int'($signed(bias))));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic directed(input string tag, input int a, input int b,
                            input int exp_act, input int exp_sat);
        acc_data  = a[ACC_W-1:0];
        bias      = b[ACC_W:0];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk({tag, "_early"}, out_valid, 0);
        cycle();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_act"}, act_data, exp_act);
        chk({tag, "_sat"}, act_sat, exp_sat);
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int bp_a[4];
        int bp_b[4];
        int idx;
        int start_out;
        bit rdy;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        acc_data = '0;
        bias = '0;
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_act_data", act_data, 0);
        chk("rst_act_sat", act_sat, 0);
        reset = 1'b0;
        cycle();

        directed("round100", 100, 0, 25, 0);
        directed("round102", 102, 0, EXP_102, 0);
        directed("relu", 50, -60, 0, 0);
        directed("sat", 1023, 100, 255, 1);
        directed("edge255", 1020, 0, 255, 0);
        chk("sat_count_1", sat_count, 1);

        // Backpressure: four offered, three fit.
        bp_a = '{10, 500, 1023, 7};
        bp_b = '{0, -20, 1023, 3};
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            acc_data = bp_a[idx][ACC_W-1:0];
            bias     = bp_b[idx][ACC_W:0];
            #1;
            rdy = in_ready;
            chk("bp_in_ready", rdy, (k < 3) ? 1 : 0);
            cycle();
            if (rdy) idx++;
        end
        for (int k = 0; k < 2; k++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_act", act_data, ref_res(bp_a[0], bp_b[0]) % 256);
            chk("bp_hold_rdy", in_ready, 0);
            cycle();
        end
        start_out = n_out;
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        for (int t = 0; t < 10 && idx < 4; t++) begin
            acc_data = bp_a[idx][ACC_W-1:0];
            bias     = bp_b[idx][ACC_W:0];
            #1;
            rdy = in_ready;
            cycle();
            if (rdy) idx++;
        end
        chk("bp_all_accepted", idx, 4);
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("bp_out_count", n_out - start_out, 4);

        // Streaming: 20 back-to-back, outputs on 20 consecutive cycles.
        start_out = n_out;
        out_ready = 1'b1;
        for (int k = 0; k < 23; k++) begin
            if (k < 20) begin
                in_valid = 1'b1;
                acc_data = ACC_W'($urandom_range(0, 1023));
                bias     = (ACC_W + 1)'($urandom_range(0, 2047));
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            chk("stream_valid", out_valid, (k >= 2 && k <= 21) ? 1 : 0);
        end
        repeat (2) cycle();
        chk("stream_count", n_out - start_out, 20);

        // Random traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            acc_data  = ACC_W'($urandom_range(0, 1023));
            bias      = (ACC_W + 1)'($urandom_range(0, 2047));
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("rand_q_empty", exp_q.size(), 0);

        // Reset while the pipeline is full and stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc_data  = 10'd1023;
        bias      = 11'd500;
        repeat (4) cycle();
        chk("stall_full", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sat_count", sat_count, 0);
        in_valid = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        directed("post_rst", 100, 0, 25, 0);
        repeat (3) cycle();
        chk("final_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
